bram_arbiter: RTL and testbench

//  Shares one single-port GPU BRAM (async read, byte-lane write) between two requesters:
//  m0 (CPU bus bridge) and m1 (GPU raster/scanout). Round-robin or fixed-priority grant,

---
 rtl/gpu_mem_pkg.sv | 10 +
 rtl/bram_arbiter_if.sv | 20 ++
 rtl/rr_arb2.sv | 24 ++
 rtl/bram_arbiter.sv | 114 +++++++++++
 tb/tb_bram_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU memory arbitration slice.
package gpu_mem_pkg;
  localparam int DP_DEF = 512;
  localparam int DW_DEF = 32;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;
endpackage

// File: rtl/bram_arbiter_if.sv
// One requester's BRAM access port: held request, combinational grant, registered read response.
interface bram_arbiter_if
  import gpu_mem_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = $clog2(DP_DEF),
  parameter int MW = DW / 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [MW-1:0] sel;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, sel, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, sel, output gnt, rvalid, rdata);
endinterface

// File: rtl/rr_arb2.sv
// Two-way arbiter; round-robin pointer advances only on a grant, or fixed m0 priority.
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr;  // 1 = requester 1 preferred on contention

  always_comb begin
    gnt = req;
    if (req == 2'b11)
      gnt = (FIXED_PRIO || !ptr) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= 1'b0;
    else if (|gnt)
      ptr <= gnt[0];
  end
endmodule

// File: rtl/bram_arbiter.sv
// Sole master of a single-port BRAM: arbitrates two requesters and runs a whole-array fill engine.
module bram_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int DP         = DP_DEF,
  parameter int DW         = DW_DEF,
  parameter int MW         = DW / 8,
  parameter int AW         = $clog2(DP),
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  bram_arbiter_if.slave m0,
  bram_arbiter_if.slave m1,
  input  logic          clear_start,
  input  logic [DW-1:0] clear_value,
  output logic          clear_busy,
  output logic          clear_done,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_wdata,
  output logic [MW-1:0] bram_sel,
  output logic          bram_we,
  input  logic [DW-1:0] bram_rdata
);
  state_t        state, state_nxt;
  logic [AW-1:0] cnt;
  logic [DW-1:0] clr_val;
  logic          last_word;
  logic          done_q;
  logic          rv0_q, rv1_q;
  logic [DW-1:0] rd0_q, rd1_q;
  logic [1:0]    arb_req, arb_gnt;

  assign last_word = (cnt == AW'(DP - 1));

  // A same-cycle clear_start blocks arbitration so the fill never races a transfer.
  assign arb_req = (!rst && state == ST_ARB && !clear_start) ? {m1.req, m0.req} : 2'b00;

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO != 0)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .gnt (arb_gnt)
  );

  always_comb begin
    state_nxt  = state;
    bram_addr  = m0.addr;
    bram_wdata = m0.wdata;
    bram_sel   = '0;
    bram_we    = 1'b0;
    case (state)
      ST_ARB: begin
        if (clear_start)
          state_nxt = ST_CLEAR;
        if (arb_gnt[1]) begin
          bram_addr  = m1.addr;
          bram_wdata = m1.wdata;
          bram_sel   = m1.sel;
          bram_we    = m1.we;
        end else if (arb_gnt[0]) begin
          bram_sel   = m0.sel;
          bram_we    = m0.we;
        end
      end
      ST_CLEAR: begin
        if (last_word)
          state_nxt = ST_ARB;
        bram_addr  = cnt;
        bram_wdata = clr_val;
        bram_sel   = '1;
        bram_we    = !rst;
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ARB;
      cnt     <= '0;
      clr_val <= '0;
      done_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == ST_CLEAR) && last_word;
      if (state == ST_ARB && clear_start) begin
        cnt     <= '0;
        clr_val <= clear_value;
      end else if (state == ST_CLEAR && !last_word) begin
        cnt <= cnt + 1'b1;
      end
      rv0_q <= arb_gnt[0] && !m0.we;
      rv1_q <= arb_gnt[1] && !m1.we;
      if (arb_gnt[0] && !m0.we)
        rd0_q <= bram_rdata;
      if (arb_gnt[1] && !m1.we)
        rd1_q <= bram_rdata;
    end
  end

  assign m0.gnt     = arb_gnt[0];
  assign m1.gnt     = arb_gnt[1];
  assign m0.rvalid  = rv0_q && !rst;
  assign m1.rvalid  = rv1_q && !rst;
  assign m0.rdata   = rst ? '0 : rd0_q;
  assign m1.rdata   = rst ? '0 : rd1_q;
  assign clear_busy = (state == ST_CLEAR) && !rst;
  assign clear_done = done_q && !rst;
endmodule

// File: tb/tb_bram_arbiter.sv
// Randomised bench for bram_arbiter against a transaction-level model of the shared BRAM.
module tb_bram_arbiter;
  localparam int DP = 512;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int MW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    s_req, s_we;
  logic [AW-1:0] s_addr [2];
  logic [DW-1:0] s_wdata[2];
  logic [MW-1:0] s_sel  [2];
  logic          cs;
  logic [DW-1:0] cv;

  bram_arbiter_if #(.DW(DW), .AW(AW)) m0_if (), m1_if (), f0_if (), f1_if ();
  assign m0_if.req = s_req[0];  assign m0_if.we = s_we[0];  assign m0_if.addr = s_addr[0];
  assign m0_if.wdata = s_wdata[0];  assign m0_if.sel = s_sel[0];
  assign m1_if.req = s_req[1];  assign m1_if.we = s_we[1];  assign m1_if.addr = s_addr[1];
  assign m1_if.wdata = s_wdata[1];  assign m1_if.sel = s_sel[1];
  assign f0_if.req = s_req[0];  assign f0_if.we = s_we[0];  assign f0_if.addr = s_addr[0];
  assign f0_if.wdata = s_wdata[0];  assign f0_if.sel = s_sel[0];
  assign f1_if.req = s_req[1];  assign f1_if.we = s_we[1];  assign f1_if.addr = s_addr[1];
  assign f1_if.wdata = s_wdata[1];  assign f1_if.sel = s_sel[1];

  logic          busy, done, b_we, f_busy, f_done, f_we;
  logic [AW-1:0] b_addr, f_addr;
  logic [DW-1:0] b_wdata, b_rdata, f_wdata, f_rdata;
  logic [MW-1:0] b_sel, f_sel;

  bram_arbiter #(.DP(DP), .DW(DW), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if),
    .clear_start(cs), .clear_value(cv), .clear_busy(busy), .clear_done(done),
    .bram_addr(b_addr), .bram_wdata(b_wdata), .bram_sel(b_sel), .bram_we(b_we),
    .bram_rdata(b_rdata)
  );

  bram_arbiter #(.DP(DP), .DW(DW), .FIXED_PRIO(1)) dut_fixed (
    .clk(clk), .rst(rst), .m0(f0_if), .m1(f1_if),
    .clear_start(1'b0), .clear_value(32'h0), .clear_busy(f_busy), .clear_done(f_done),
    .bram_addr(f_addr), .bram_wdata(f_wdata), .bram_sel(f_sel), .bram_we(f_we),
    .bram_rdata(f_rdata)
  );
  assign f_rdata = {23'b0, f_addr};

  // Physical BRAM behind the main instance
  logic          preload;
  logic [DW-1:0] init_img[DP];
  logic [DW-1:0] bram[DP];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DP; i++) bram[i] <= init_img[i];
    end else if (b_we) begin
      for (int b = 0; b < MW; b++)
        if (b_sel[b]) bram[b_addr][8*b +: 8] <= b_wdata[8*b +: 8];
    end
  end
  assign b_rdata = bram[b_addr];

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory image, pending responses, clear progress, round-robin preference
  logic [DW-1:0] ref_mem[DP];
  bit            m_clr, m_done;
  int            m_idx, m_pref;
  logic [DW-1:0] m_cval;
  bit            m_rv[2];
  logic [DW-1:0] m_rd[2];
  bit            last_g[2];
  bit            obs_g[2], obs_f[2];
  int            busy_seen, done_seen;

  task automatic tick();
    bit g[2];
    int w, fw;
    logic ewe;
    logic [DW-1:0] t;
    @(negedge clk);
    g = '{1'b0, 1'b0};
    w = -1;
    if (!rst && !m_clr && !cs) begin
      if (s_req == 2'b11) w = m_pref;
      else if (s_req[0])  w = 0;
      else if (s_req[1])  w = 1;
    end
    if (w >= 0) g[w] = 1'b1;
    chk("gnt0", m0_if.gnt, g[0]);
    chk("gnt1", m1_if.gnt, g[1]);
    chk("busy", busy, !rst && m_clr);
    chk("done", done, !rst && m_done);
    chk("rvalid0", m0_if.rvalid, !rst && m_rv[0]);
    chk("rvalid1", m1_if.rvalid, !rst && m_rv[1]);
    chk("rdata0", m0_if.rdata, rst ? 32'h0 : m_rd[0]);
    chk("rdata1", m1_if.rdata, rst ? 32'h0 : m_rd[1]);
    ewe = rst ? 1'b0 : m_clr ? 1'b1 : (w >= 0) ? s_we[w] : 1'b0;
    chk("bram_we", b_we, ewe);
    if (!rst && !m_clr && w < 0) chk("idle_addr", b_addr, s_addr[0]);
    if (!rst && m_clr) chk("clr_addr", b_addr, m_idx);
    fw = rst ? -1 : s_req[0] ? 0 : s_req[1] ? 1 : -1;
    chk("fix_gnt0", f0_if.gnt, fw == 0);
    chk("fix_gnt1", f1_if.gnt, fw == 1);
    obs_g[0] = m0_if.gnt;  obs_g[1] = m1_if.gnt;
    obs_f[0] = f0_if.gnt;  obs_f[1] = f1_if.gnt;
    if (busy) busy_seen++;
    if (done) done_seen++;
    @(posedge clk);
    if (rst) begin
      m_clr = 0; m_done = 0; m_pref = 0;
      m_rv = '{1'b0, 1'b0};
      m_rd = '{32'h0, 32'h0};
    end else begin
      m_done = 0;
      m_rv = '{1'b0, 1'b0};
      if (m_clr) begin
        ref_mem[m_idx] = m_cval;
        if (m_idx == DP - 1) begin m_clr = 0; m_done = 1; end
        else m_idx++;
      end else if (cs) begin
        m_clr = 1; m_idx = 0; m_cval = cv;
      end else if (w >= 0) begin
        if (s_we[w]) begin
          t = ref_mem[s_addr[w]];
          for (int b = 0; b < MW; b++)
            if (s_sel[w][b]) t[8*b +: 8] = s_wdata[w][8*b +: 8];
          ref_mem[s_addr[w]] = t;
        end else begin
          m_rv[w] = 1; m_rd[w] = ref_mem[s_addr[w]];
        end
        m_pref = 1 - w;
      end
    end
    last_g = g;
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic we, input int a,
                          input logic [31:0] d, input logic [3:0] s);
    s_req[p] = r; s_we[p] = we; s_addr[p] = AW'(a); s_wdata[p] = d; s_sel[p] = s;
  endtask

  function automatic int count_bad(input int lo, input int hi, input logic [31:0] v);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (bram[i] !== v) n++;
    return n;
  endfunction

  initial begin
    int n, served;
    logic [7:0] pat, fpat;
    rst = 1; preload = 1; cs = 0; cv = '0;
    for (int p = 0; p < 2; p++) set_port(p, 0, 0, 0, 0, 0);
    for (int i = 0; i < DP; i++) init_img[i] = $urandom;
    init_img[5] = 32'hA5A5A5A5;
    init_img[3] = 32'h0;
    for (int i = 0; i < DP; i++) ref_mem[i] = init_img[i];
    m_pref = 0;
    repeat (3) tick();
    preload = 0; rst = 0;

    // 1: single read, latency 1
    set_port(0, 1, 0, 5, 0, 0);
    tick();
    set_port(0, 0, 0, 5, 0, 0);
    tick();
    chk("t1_rdata", m0_if.rdata, 32'hA5A5A5A5);

    // 2: contention, RR vs fixed priority, from a fresh pointer
    rst = 1; tick(); rst = 0;
    set_port(0, 1, 0, 7, 0, 0);
    set_port(1, 1, 0, 8, 0, 0);
    pat = '0; fpat = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pat  = {pat[5:0], obs_g[0], obs_g[1]};
      fpat = {fpat[5:0], obs_f[0], obs_f[1]};
    end
    chk("t2_rr_pattern", pat, 8'b10_01_10_01);
    chk("t2_fixed_pattern", fpat, 8'b10_10_10_10);
    set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0);

    // 3: byte-lane write
    set_port(1, 1, 1, 3, 32'h11223344, 4'b0100);
    tick();
    set_port(1, 0, 0, 0, 0, 0);
    tick();
    chk("t3_mem", bram[3], 32'h00220000);
    chk("t3_norv", m1_if.rvalid, 1'b0);

    // 4: clear beats a same-cycle request
    busy_seen = 0; done_seen = 0; served = 0;
    cs = 1; cv = 32'hDEADBEEF;
    set_port(0, 1, 0, 9, 0, 0);
    tick();
    cs = 0;
    for (int i = 0; i < 600 && !served; i++) begin
      tick();
      if (last_g[0]) served = 1;
    end
    set_port(0, 0, 0, 0, 0, 0);
    chk("t4_m0_served", served, 1);
    chk("t4_busy_cycles", busy_seen, DP);
    chk("t4_done_pulses", done_seen, 1);
    chk("t4_fill", count_bad(0, DP - 1, 32'hDEADBEEF), 0);
    tick();

    // 5: reset aborts a clear at word 100
    cs = 1; cv = 32'h12345678;
    tick();
    cs = 0; done_seen = 0;
    repeat (100) tick();
    rst = 1; repeat (2) tick(); rst = 0;
    busy_seen = 0;
    repeat (20) tick();
    chk("t5_done_pulses", done_seen, 0);
    chk("t5_busy_after", busy_seen, 0);
    chk("t5_filled", count_bad(0, 99, 32'h12345678), 0);
    chk("t5_untouched", count_bad(100, DP - 1, 32'hDEADBEEF), 0);

    // 6: pending read survives a clear; second clear_start while busy ignored
    set_port(0, 1, 0, 200, 0, 0);
    tick();
    set_port(0, 0, 0, 0, 0, 0);
    cs = 1; cv = 32'h55AA55AA;
    tick();
    cs = 0; done_seen = 0;
    repeat (50) tick();
    cs = 1; cv = 32'h0;
    tick();
    cs = 0;
    repeat (520) tick();
    chk("t6_done_pulses", done_seen, 1);
    chk("t6_fill", count_bad(0, DP - 1, 32'h55AA55AA), 0);

    // Random traffic with occasional clears and resets
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (s_req[p] && last_g[p]) s_req[p] = 0;
        if (!s_req[p] && $urandom_range(0, 2) != 0)
          set_port(p, 1, 1'($urandom_range(0, 1)), $urandom_range(0, DP - 1),
                   $urandom, 4'($urandom_range(0, 15)));
      end
      cs  = ($urandom_range(0, 299) == 0);
      cv  = $urandom;
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 0; cs = 0;
    s_req = 2'b00;
    repeat (2) tick();
    n = 0;
    for (int i = 0; i < DP; i++) if (bram[i] !== ref_mem[i]) n++;
    chk("final_mem", n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
